receive: RTL and testbench
==========================

RECEIVE -- requirements
Module: receive

Interface
REQ-001 Parameter D, default 234, clock cycles per bit period (D >= 4).
REQ-002 Parameter L, default 8, data bits per frame (1..8).
REQ-003 i_clk  input  1  sole clock; all state on rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_rxd  input  1  serial line, idle high, asynchronous to i_clk.
REQ-006 o_data  output  L  last correctly received byte, held until the next good frame (LED-drivable).
REQ-007 o_valid  output  1  one-cycle pulse when o_data updates.
REQ-008 o_err  output  1  one-cycle pulse on framing (or parity) error.
REQ-009 o_busy  output  1  high while a frame is in progress (any state other than IDLE).

Function
REQ-010 i_rxd SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value rxs.
REQ-011 Frame SHALL be: start bit (0), L data bits LSB first, optional parity bit (REQ-028), one stop bit (1).
REQ-012 States SHALL be IDLE, START, DATA, PARITY (only when enabled), STOP.
REQ-013 IDLE -> START SHALL occur on a falling edge of rxs (previous 1, current 0); a constant-low line SHALL NOT start a frame.
REQ-014 In START, the bit counter SHALL load D/2 (integer division); on expiry rxs is sampled: 0 -> DATA, 1 -> IDLE (glitch rejected, no o_err).
REQ-015 In DATA/PARITY/STOP, each sample SHALL occur D cycles after the previous sample point (mid-bit).
REQ-016 Data bits SHALL be shifted into a shift register; the bit index SHALL count 0..L-1, then advance to PARITY or STOP.
REQ-017 At the STOP sample: rxs=1 and no parity error -> o_data <= shift register and o_valid=1 in the following cycle; otherwise o_err=1 and o_data unchanged.
REQ-018 After the STOP sample the FSM SHALL return to IDLE in the same transition, so a start edge is accepted from the next cycle.
REQ-019 o_valid and o_err SHALL never both be high and SHALL each last exactly one cycle.
REQ-020 Latency: the o_valid pulse occurs D/2 + (L+P+1)*D + 1 cycles after the first low rxs, where P=1 with parity, else 0.
REQ-021 After a framing error with the line held low (break), the FSM SHALL stay in IDLE until rxs returns to 1 and falls again.
REQ-022 Input changes in the middle of a bit SHALL have no effect; only the sample points matter.

Reset
REQ-023 While i_rst=1: state=IDLE, counters=0, shift register=0, o_data=0, o_valid=0, o_err=0, o_busy=0, synchronizer flops=1.
REQ-024 Reset mid-frame SHALL abandon the frame without an o_valid or o_err pulse; o_data SHALL read 0.
REQ-025 After reset release, a frame already in progress on the line SHALL be ignored until a fresh falling edge occurs.

Configuration
REQ-026 Macro RECEIVE_PARITY_EN SHALL select the parity feature.
REQ-027 Undefined: no PARITY state; frame = start + L data + stop.
REQ-028 Defined: an even-parity bit follows the data bits and is sampled in PARITY; a mismatch SHALL produce o_err at the STOP sample instead of o_valid, with o_data unchanged.

Verification
REQ-029 Frame 0x02, D=234, clean line -> one o_valid pulse, o_data=0x02, o_err never high, o_busy low afterwards.
REQ-030 Back-to-back frames 0xA5 then 0x3C with no idle gap -> two o_valid pulses; o_data=0xA5 then 0x3C.
REQ-031 Low glitch of 50 cycles on an idle line -> returns to IDLE after D/2 cycles; no o_valid, no o_err.
REQ-032 Frame 0x55 with stop bit forced to 0 -> o_err pulse, o_data keeps its previous value; a following good 0x01 -> o_valid, o_data=0x01.
REQ-033 i_rst asserted after data bit 3 of 0xFF -> all outputs 0 immediately; the next 0x81 frame is received correctly.
REQ-034 With RECEIVE_PARITY_EN: 0x07 with correct parity 1 -> o_valid; the same frame with parity 0 -> o_err and o_data unchanged.

Source files
------------

// File: rtl/receive.sv
// receive: UART-style serial frame receiver.
//
// Frame on the line: start bit (0), L data bits LSB first, optional even
// parity bit, one stop bit (1). The line is idle high and asynchronous to
// i_clk; it is resynchronised by two flops before any logic looks at it.
//
// Build option:
//   RECEIVE_PARITY_EN  defined   -> an even-parity bit follows the data bits;
//                                   a parity mismatch turns the frame's
//                                   completion into an o_err pulse.
//                      undefined -> no parity bit (default build).
//
// Parameters:
//   D  clock cycles per bit period (D >= 4)
//   L  data bits per frame (1..8)
//
// Ports:
//   i_clk    sole clock, all state on the rising edge
//   i_rst    asynchronous active-high reset
//   i_rxd    serial line input, idle high
//   o_data   last correctly received word, held until the next good frame
//   o_valid  one-cycle pulse when o_data updates
//   o_err    one-cycle pulse on a framing or parity error
//   o_busy   high while a frame is in progress (FSM not in IDLE)
//
// State table:
//   state  | meaning
//   IDLE   | waiting for a falling edge on the synchronised line
//   START  | half-bit wait, then confirm the start bit is still low
//   DATA   | sampling L data bits at mid-bit, one every D cycles
//   PARITY | sampling the even-parity bit (RECEIVE_PARITY_EN only)
//   STOP   | sampling the stop bit and publishing the word or an error

module receive #(
    parameter int D = 234,
    parameter int L = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_rxd,
    output logic [L-1:0] o_data,
    output logic         o_valid,
    output logic         o_err,
    output logic         o_busy
);

    localparam int CW = $clog2(D);
    localparam int IW = (L > 1) ? $clog2(L) : 1;

    // The bit timer is a down-counter; a sample is taken on the cycle it
    // reads zero, so loading N-1 yields a sample N cycles later.
    localparam logic [CW-1:0] HALF_LD  = CW'(D / 2 - 1);
    localparam logic [CW-1:0] FULL_LD  = CW'(D - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(L - 1);

`ifdef RECEIVE_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd4
    } state_t;
`endif

    // ------------------------------------------------------------------
    // Line synchroniser and start-edge detection
    // ------------------------------------------------------------------
    logic       rx_meta;
    logic       rxs;
    logic       rxs_prev;
    logic [2:0] settle;
    logic       start_edge;

    // The synchroniser flops come out of reset reading 1, so for the first
    // few cycles after release rxs/rxs_prev do not reflect the real line.
    // settle masks edge detection until both carry genuine samples; this
    // keeps a line that was already low at release from posing as a start.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
            settle   <= 3'b000;
        end else begin
            rx_meta  <= i_rxd;
            rxs      <= rx_meta;
            rxs_prev <= rxs;
            settle   <= {settle[1:0], 1'b1};
        end
    end

    assign start_edge = settle[2] & rxs_prev & ~rxs;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [L-1:0]    shreg_q, shreg_d;
    logic [L-1:0]    data_q, data_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic            tc;
    logic            frame_ok;
`ifdef RECEIVE_PARITY_EN
    logic            par_err_q, par_err_d;
`endif

    assign tc = (cnt_q == '0);

`ifdef RECEIVE_PARITY_EN
    assign frame_ok = rxs & ~par_err_q;
`else
    assign frame_ok = rxs;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
`ifdef RECEIVE_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
`ifdef RECEIVE_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
`ifdef RECEIVE_PARITY_EN
        par_err_d = par_err_q;
`endif

        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d = START;
                    cnt_d   = HALF_LD;
                end
            end

            START: begin
                if (tc) begin
                    // Still low at mid start bit: a real frame. Otherwise it
                    // was a glitch and is dropped silently.
                    if (!rxs) begin
                        state_d   = DATA;
                        cnt_d     = FULL_LD;
                        idx_d     = '0;
`ifdef RECEIVE_PARITY_EN
                        par_err_d = 1'b0;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            DATA: begin
                if (tc) begin
                    // LSB arrives first, so shift right and insert at the top;
                    // after L samples the first bit sits in bit 0.
                    shreg_d        = shreg_q >> 1;
                    shreg_d[L-1]   = rxs;
                    cnt_d          = FULL_LD;
                    if (idx_q == LAST_IDX) begin
`ifdef RECEIVE_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

`ifdef RECEIVE_PARITY_EN
            PARITY: begin
                if (tc) begin
                    // Even parity: the parity bit equals the XOR of the data.
                    par_err_d = rxs ^ (^shreg_q);
                    state_d   = STOP;
                    cnt_d     = FULL_LD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
`endif

            STOP: begin
                if (tc) begin
                    if (frame_ok) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                    end
                    // Straight back to IDLE so the next start edge can be
                    // taken on the following cycle (back-to-back frames).
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_err   = err_q;
    assign o_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_receive.sv
module tb_receive;

    localparam int D = 234;
    localparam int L = 8;
`ifdef RECEIVE_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    // Cycles from the clock edge preceding the start-bit fall on i_rxd to
    // the edge after which the completion pulse is visible: two synchroniser
    // stages, one detect cycle, half a bit, the remaining bits, one output cycle.
    localparam int LAT = 3 + D / 2 + (L + P + 1) * D;

    logic         i_clk;
    logic         i_rst;
    logic         i_rxd;
    logic [L-1:0] o_data;
    logic         o_valid;
    logic         o_err;
    logic         o_busy;

    receive #(.D(D), .L(L)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_rxd   (i_rxd),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_err   (o_err),
        .o_busy  (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        bit           is_err;
        logic [L-1:0] data;
        int           when;
    } exp_t;

    exp_t         q[$];
    int           checks = 0;
    int           errors = 0;
    logic [L-1:0] model_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every completion pulse must match the oldest expectation.
    initial begin
        exp_t e;
        bit   prev_pulse;
        prev_pulse = 1'b0;
        forever begin
            @(negedge i_clk);
            if (prev_pulse) begin
                chk("pulse_width", 32'({o_valid, o_err}), 32'd0);
            end else if (o_valid || o_err) begin
                if (q.size() == 0) begin
                    chk("unexpected_pulse", 32'({o_valid, o_err}), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("kind_err",   32'(o_err),   32'(e.is_err));
                    chk("kind_valid", 32'(o_valid), 32'(!e.is_err));
                    chk("data",       32'(o_data),  32'(e.data));
                    chk("latency",    32'(cyc),     32'(e.when));
                end
            end
            prev_pulse = o_valid | o_err;
        end
    end

    initial begin
        repeat (150000) @(posedge i_clk);
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // All drivers are entered and left 1 time unit after a rising edge.
    task automatic drive_bit(input logic v, input bit glitch);
        i_rxd = v;
        for (int c = 0; c < D; c++) begin
            if (glitch && c == 20) i_rxd = ~v;
            if (glitch && c == 40) i_rxd = v;
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        i_rxd = 1'b1;
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic send_frame(input logic [L-1:0] data, input logic stop_v,
                              input bit par_bad, input bit glitch);
        exp_t e;
        bit   bad;
        logic par_bit;
        bad = (stop_v !== 1'b1) || (P == 1 && par_bad);
        if (!bad) model_data = data;
        e.is_err = bad;
        e.data   = model_data;
        e.when   = cyc + LAT;
        q.push_back(e);
        par_bit = logic'(($countones(data) % 2) == 1) ^ logic'(par_bad);
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < L; i++) drive_bit(data[i], glitch);
        if (P == 1) drive_bit(par_bit, 1'b0);
        drive_bit(stop_v, 1'b0);
    endtask

    initial begin
        logic [L-1:0] d;
        bit           stop_ok;
        bit           pb;
        bit           gl;

        i_rst      = 1'b1;
        i_rxd      = 1'b1;
        model_data = '0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_data",  32'(o_data),  32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_err",   32'(o_err),   32'd0);
        chk("rst_busy",  32'(o_busy),  32'd0);
        i_rst = 1'b0;
        idle(10);

        // Single clean frame.
        send_frame(8'h02, 1'b1, 1'b0, 1'b0);
        idle(D);
        chk("busy_after_02", 32'(o_busy), 32'd0);
        chk("data_02",       32'(o_data), 32'(model_data));

        // Back-to-back frames, no idle gap.
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        idle(D);
        chk("busy_after_b2b", 32'(o_busy), 32'd0);
        chk("data_3c",        32'(o_data), 32'(model_data));

        // 50-cycle low glitch on an idle line.
        i_rxd = 1'b0;
        repeat (10) @(posedge i_clk);
        #1;
        chk("glitch_busy_hi", 32'(o_busy), 32'd1);
        repeat (40) @(posedge i_clk);
        #1;
        i_rxd = 1'b1;
        repeat (50) @(posedge i_clk);
        #1;
        chk("glitch_busy_start", 32'(o_busy), 32'd1);
        repeat (30) @(posedge i_clk);
        #1;
        chk("glitch_busy_lo", 32'(o_busy), 32'd0);
        idle(D);

        // Stop bit forced low, line held low (break), then a good frame.
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        i_rxd = 1'b0;
        repeat (2 * D) @(posedge i_clk);
        #1;
        chk("break_busy",     32'(o_busy), 32'd0);
        chk("data_after_err", 32'(o_data), 32'(model_data));
        idle(D);
        send_frame(8'h01, 1'b1, 1'b0, 1'b0);
        idle(D);
        chk("data_01", 32'(o_data), 32'(model_data));

        // Reset in the middle of data bit 4 of 0xFF.
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0);
        i_rxd = 1'b1;
        repeat (D / 2) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        model_data = '0;
        #1;
        chk("abort_data",  32'(o_data),  32'(model_data));
        chk("abort_valid", 32'(o_valid), 32'd0);
        chk("abort_err",   32'(o_err),   32'd0);
        chk("abort_busy",  32'(o_busy),  32'd0);
        repeat (5) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        idle(20);
        send_frame(8'h81, 1'b1, 1'b0, 1'b0);
        idle(D);
        chk("data_81", 32'(o_data), 32'(model_data));

`ifdef RECEIVE_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0, 1'b0);
        idle(D);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        idle(D);
        chk("parity_data_hold", 32'(o_data), 32'(model_data));
`endif

        // Randomised frames: data, stop errors, parity errors, mid-bit glitches.
        for (int n = 0; n < 12; n++) begin
            d       = L'($urandom);
            stop_ok = ($urandom_range(0, 5) != 0);
            pb      = ($urandom_range(0, 3) == 0);
            gl      = ($urandom_range(0, 1) == 1);
            send_frame(d, stop_ok, pb, gl);
            if (!stop_ok) idle(D + $urandom_range(0, 20));
            else          idle($urandom_range(0, 30));
        end

        for (int t = 0; t < 4 * D && q.size() > 0; t++) @(posedge i_clk);
        idle(D);
        chk("drain",      32'(q.size()), 32'd0);
        chk("final_busy", 32'(o_busy),   32'd0);
        chk("final_data", 32'(o_data),   32'(model_data));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
